// File: rtl/ex_branch_stage.sv
// Execute stage: operand forwarding, ALU, BTFN branch/jump resolution with same-cycle redirect,
// EX/MEM pipeline register and saturating branch/mispredict performance counters.
module ex_branch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [31:0] ImmExtendE,
  input  logic [4:0]  rdE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  rdM,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic        RedirectE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  logic [31:0] src_a;
  logic [31:0] write_data_e;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] pc_target;
  logic        zero;
  logic        is_branch;
  logic        actual_taken;
  logic        pred_taken;
  logic        mispredict;

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Forwarding muxes; select 11 falls back to the register file operand.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = rd1E;
    endcase
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = ALUResultM;
      default: write_data_e = rd2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtendE : write_data_e;

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_result = 32'b0;
    endcase
  end

  assign zero      = (alu_result == 32'b0);
  assign pc_target = PCE + ImmExtendE;

  // BTFN: fetch already followed backward branches, so only disagreement redirects.
  assign is_branch    = BranchE & ~JumpE;
  assign pred_taken   = ImmExtendE[31];
  assign actual_taken = zero;
  assign mispredict   = is_branch & (pred_taken != actual_taken);

  always_comb begin
    RedirectE   = 1'b0;
    RedirectPCE = 32'b0;
    if (JumpE) begin
      RedirectE   = 1'b1;
      RedirectPCE = pc_target;
    end else if (mispredict) begin
      RedirectE   = 1'b1;
      RedirectPCE = actual_taken ? pc_target : PCPlus4E;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (is_branch && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResultM    <= 32'b0;
      WriteDataM    <= 32'b0;
      PCPlus4M      <= 32'b0;
      rdM           <= 5'b0;
      RegWriteM     <= 1'b0;
      MemWriteM     <= 1'b0;
      ResultSrcM    <= 2'b0;
      branch_cnt_q  <= 32'b0;
      mispred_cnt_q <= 32'b0;
    end else begin
      ALUResultM    <= alu_result;
      WriteDataM    <= write_data_e;
      PCPlus4M      <= PCPlus4E;
      rdM           <= rdE;
      RegWriteM     <= RegWriteE;
      MemWriteM     <= MemWriteE;
      ResultSrcM    <= ResultSrcE;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispred_cnt_q;

endmodule
